// File: rtl/sprite_pkg.sv
// Shared sprite/tile ROM definitions: widths, the RGB888 pixel type and the
// colour key that downstream consumers treat as transparent.
package sprite_pkg;

    localparam int ROM_ADDR_W = 19;
    localparam int RGB_W      = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t TRANSPARENT_RGB = 24'hee35ff;

endpackage

// File: rtl/rom_tag_pipe.sv
// Carries {valid, one-hot requester tag} alongside the ROM read latency so the
// returned word can be steered back to the requester that issued the read.
module rom_tag_pipe #(
    parameter int N_REQ   = 4,
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [N_REQ-1:0] push_tag,
    output logic             pop_valid,
    output logic [N_REQ-1:0] pop_tag
);

    logic [ROM_LAT-1:0][N_REQ:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= {push_valid, push_tag};
            for (int i = 1; i < ROM_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop_valid = stage_q[ROM_LAT-1][N_REQ];
    assign pop_tag   = stage_q[ROM_LAT-1][N_REQ-1:0];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite ROM port: strict priority for the pixel
// path during active video, round-robin among all requesters during blanking.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = RGB_W,
    parameter int ROM_LAT = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    blank,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  last_gnt;
    logic [ADDR_W-1:0] last_addr;
    logic              win_found;
    logic              win_prio;
    logic [IDX_W-1:0]  win_idx;
    logic              grant_ok;
    logic              pop_valid;
    logic [N_REQ-1:0]  pop_tag;

    // Search starts just past the last round-robin winner and wraps once.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_prio  = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (blank && req[0]) begin
            win_found = 1'b1;
            win_prio  = 1'b1;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = int'(last_gnt) + k;
                if (cand >= N_REQ) cand -= N_REQ;
                cand_idx = IDX_W'(cand);
                if (!win_found && req[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    assign grant_ok = win_found && Reset_n;

    always_comb begin
        gnt      = '0;
        rom_addr = last_addr;
        if (grant_ok) begin
            gnt[win_idx] = 1'b1;
            rom_addr     = addr[int'(win_idx)*ADDR_W +: ADDR_W];
        end
    end

    // Pixel-path priority grants leave the pointer alone so blanking fairness survives.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_gnt  <= IDX_W'(N_REQ - 1);
            last_addr <= '0;
        end else if (grant_ok) begin
            last_addr <= rom_addr;
            if (!win_prio) begin
                last_gnt <= win_idx;
            end
        end
    end

    rom_tag_pipe #(
        .N_REQ  (N_REQ),
        .ROM_LAT(ROM_LAT)
    ) u_tag_pipe (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push_valid(grant_ok),
        .push_tag  (gnt),
        .pop_valid (pop_valid),
        .pop_tag   (pop_tag)
    );

    assign rd_valid = pop_valid ? pop_tag : '0;
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural arbitration/ROM model
// checked every cycle plus literal spot checks.
module tb_sprite_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 19;
    localparam int DW  = 24;
    localparam int LAT = 2;

    logic            Clk     = 1'b0;
    logic            Reset_n = 1'b0;
    logic            blank   = 1'b0;
    logic [N-1:0]    req     = '0;
    logic [N*AW-1:0] addr    = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;

    int checks = 0;
    int errors = 0;

    sprite_rom_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .ROM_LAT(LAT)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .blank   (blank),
        .req     (req),
        .addr    (addr),
        .gnt     (gnt),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rd_valid(rd_valid),
        .rd_data (rd_data)
    );

    always #10 Clk = ~Clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a[7:0], a[15:8] ^ 8'hA5, {5'd0, a[18:16]} ^ 8'h3C};
    endfunction

    // Synchronous ROM with LAT cycles from sampled address to data.
    logic [DW-1:0] rom_q [LAT];
    always @(posedge Clk) begin
        rom_q[0] <= rom_f(rom_addr);
        for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
    end
    assign rom_data = rom_q[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        int            idx;
        logic [AW-1:0] a;
    } rd_t;

    rd_t           pend[$];
    int            ptr       = N - 1;
    logic [AW-1:0] last_addr = '0;
    int            cyc       = 0;

    task automatic checkOutput();
        int            w;
        bit            prio;
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rdv;
        logic [DW-1:0] exp_rdd;
        rd_t           keep[$];
        if (!Reset_n) begin
            chk("model_gnt_rst", gnt, '0);
            chk("model_addr_rst", rom_addr, '0);
            chk("model_rdv_rst", rd_valid, '0);
            pend.delete();
            ptr       = N - 1;
            last_addr = '0;
            cyc++;
            return;
        end
        w    = -1;
        prio = 0;
        if (blank && req[0]) begin
            w    = 0;
            prio = 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
            end
        end
        exp_gnt  = (w >= 0) ? N'(1 << w) : '0;
        exp_addr = (w >= 0) ? addr[w*AW +: AW] : last_addr;
        exp_rdv  = '0;
        exp_rdd  = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                exp_rdv = N'(1 << pend[i].idx);
                exp_rdd = rom_f(pend[i].a);
            end else if (pend[i].due > cyc) begin
                keep.push_back(pend[i]);
            end
        end
        chk("model_gnt", gnt, exp_gnt);
        chk("model_rom_addr", rom_addr, exp_addr);
        chk("model_rd_valid", rd_valid, exp_rdv);
        if (exp_rdv != '0) chk("model_rd_data", rd_data, exp_rdd);
        pend = keep;
        if (w >= 0) begin
            pend.push_back('{cyc + LAT, w, exp_addr});
            last_addr = exp_addr;
            if (!prio) ptr = w;
        end
        cyc++;
    endtask

    always @(negedge Clk) checkOutput();

    task automatic applyStimulus(input logic rst, input logic bl, input logic [N-1:0] rq,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        @(posedge Clk);
        #2;
        Reset_n = rst;
        blank   = bl;
        req     = rq;
        addr    = {a3, a2, a1, a0};
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    localparam logic [AW-1:0] A0 = 19'h00100;
    localparam logic [AW-1:0] A1 = 19'h11111;
    localparam logic [AW-1:0] A2 = 19'h22222;
    localparam logic [AW-1:0] A3 = 19'h33333;

    logic [N-1:0] rr_seq [5];

    initial begin
        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset with a request pending: nothing may be granted, address stays 0.
        addr = {A3, A2, A1, A0};
        req  = 4'b0100;
        settle();
        chk("reset_gnt", gnt, '0);
        chk("reset_rom_addr", rom_addr, '0);
        chk("reset_rd_valid", rd_valid, '0);

        applyStimulus(1, 0, 4'b0100, A0, A1, A2, A3);
        settle();
        chk("rst_read_gnt", gnt, 4'b0100);
        chk("rst_read_addr", rom_addr, A2);
        applyStimulus(0, 0, 4'b0000, A0, A1, A2, A3);
        settle();
        chk("mid_reset_gnt", gnt, '0);
        chk("mid_reset_rom_addr", rom_addr, '0);
        applyStimulus(1, 0, 4'b0000, A0, A1, A2, A3);
        settle();
        chk("no_stale_rd_a", rd_valid, '0);
        applyStimulus(1, 0, 4'b0000, A0, A1, A2, A3);
        settle();
        chk("no_stale_rd_b", rd_valid, '0);
        applyStimulus(1, 0, 4'b1111, A0, A1, A2, A3);
        settle();
        chk("first_rr_gnt", gnt, 4'b0001);

        // Active video: pixel path wins every cycle and the pointer stays put.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 4'b1111, A0 + AW'(i), A1, A2, A3);
            settle();
            chk("pixel_prio_gnt", gnt, 4'b0001);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 4'b1111, A0, A1 + AW'(i), A2 + AW'(i), A3 + AW'(i));
            settle();
            chk("rr_seq_gnt", gnt, rr_seq[i]);
        end

        applyStimulus(1, 0, 4'b1000, A0, A1, A2, A3);
        settle();
        chk("wrap_setup_gnt", gnt, 4'b1000);
        applyStimulus(1, 0, 4'b0100, A0, A1, A2, A3);
        settle();
        chk("wrap_gnt_2", gnt, 4'b0100);
        applyStimulus(1, 0, 4'b0101, A0, A1, A2, A3);
        settle();
        chk("wrap_gnt_0", gnt, 4'b0001);
        applyStimulus(1, 0, 4'b0101, A0, A1, A2, A3);
        settle();
        chk("wrap_gnt_2b", gnt, 4'b0100);

        // Active video without the pixel path falls back to round-robin.
        applyStimulus(1, 1, 4'b0110, A0, 19'h5A5A5, 19'h7FFFF, A3);
        settle();
        chk("blank_rr_gnt_1", gnt, 4'b0010);
        applyStimulus(1, 1, 4'b0110, A0, 19'h5A5A5, 19'h7FFFF, A3);
        settle();
        chk("blank_rr_gnt_2", gnt, 4'b0100);

        // Mode switch with requester 3 in flight.
        applyStimulus(1, 0, 4'b1000, A0, A1, A2, 19'h3ABCD);
        settle();
        chk("mode_gnt3", gnt, 4'b1000);
        applyStimulus(1, 1, 4'b1001, 19'h0F0F0, A1, A2, 19'h3ABCD);
        settle();
        chk("mode_gnt0", gnt, 4'b0001);
        applyStimulus(1, 1, 4'b0000, 19'h0F0F0, A1, A2, 19'h3ABCD);
        settle();
        chk("mode_rd3_valid", rd_valid, 4'b1000);
        chk("mode_rd3_data", rd_data, rom_f(19'h3ABCD));

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 4'b0000, A0, A1, A2, A3);
            settle();
            chk("idle_gnt", gnt, '0);
            chk("idle_rom_addr", rom_addr, 19'h0F0F0);
            if (i == 0) chk("idle_rd0_valid", rd_valid, 4'b0001);
        end

        applyStimulus(1, 0, 4'b0000, A0, A1, A2, A3);
        @(posedge Clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous-read sprite/tile ROM port among several requesters (the per-pixel color path plus background/sprite prefetch engines). Grants at most one read per clock, drives the ROM address, and routes the returned 24-bit RGB word back to the requester that issued it. During active video, requester 0 (the pixel path) has strict priority. During blanking, all requesters share round-robin.

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 is the pixel path
- ADDR_W, 19, ROM address width
- DATA_W, 24, ROM data width (RGB888)
- ROM_LAT, 1, clocks from address sampled to ROM data valid (1..4)

Ports:
- Clk  in  1  single clock, 50 MHz; all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- blank  in  1  1 = active video (same sense as the VGA controller's blank), 0 = blanking interval
- req  in  N_REQ  per-requester read request; level, held until granted
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational in the request cycle
- rom_addr  out  ADDR_W  address to the ROM's read_address
- rom_data  in  DATA_W  ROM data_Out
- rd_valid  out  N_REQ  one-hot, one cycle; rd_data belongs to the flagged requester
- rd_data  out  DATA_W  returned word

## Operation
- Each cycle, the arbiter picks a winner among asserted req bits:
  - If blank=1 and req[0]=1, the winner is 0.
  - Otherwise, the winner is the first asserted requester searching from last_gnt+1 upward, with wrap-around.
- gnt = one-hot of the winner, or all zero if no req.
- rom_addr = winner's addr. With no winner, rom_addr holds its last granted value; it is 0 after reset.
- last_gnt updates only on a grant, and only for round-robin grants. Strict-priority grants to 0 do not move the pointer, so blanking-time fairness is preserved.
- Requester protocol:
  - A requester drops req or changes addr only in the cycle after seeing gnt.
  - Back-to-back grants to the same requester are legal if its req stays high and no other requester wins.
- Return path:
  - A ROM_LAT-deep pipeline carries {valid, one-hot tag}.
  - rd_valid = tag of the stage-ROM_LAT entry when it is valid.
  - rd_data = rom_data, passed through combinationally with no extra register.
- Mode switch: a change of blank takes effect in the same cycle. In-flight reads complete regardless of mode.
- Reset (Reset_n low, any time):
  - gnt forced 0; rd_valid = 0; tag pipeline cleared; last_gnt = N_REQ-1, so requester 0 wins the first round-robin pass; rom_addr = 0.
  - Grants issued before reset never produce rd_valid after release.
- Out-of-range or X addresses are passed through unchecked.

## Timing
- Grant latency: 0 cycles; gnt is asserted in the same cycle req is seen.
- Read latency: grant in cycle t gives rd_valid and rd_data in cycle t+ROM_LAT.
- Throughput: one read per cycle, sustained.
- Starvation: during active video with req[0] held high, requesters 1..N-1 receive no grants. This is required behaviour; the pixel path must never stall.
- During blanking, every continuously requesting requester is granted within N_REQ cycles.
- Combinational path: req/addr/blank -> gnt/rom_addr is one priority encoder plus a mux and must close at 50 MHz.

## Structure
- Shared package sprite_pkg:
  - ROM_ADDR_W and RGB_W constants.
  - rgb_t typedef (24-bit packed struct r/g/b).
  - TRANSPARENT_RGB = 24'hee35ff, for downstream consumers.
- Sub-module rom_tag_pipe:
  - Parameterized ROM_LAT-deep shift register of {valid, N_REQ tag}.
  - Asynchronous active-low clear.
- Top level contains the priority/round-robin encoder and the last_gnt register.

## Test plan
- Reset mid-read: grant requester 2 with ROM_LAT=2, then pulse Reset_n low for one cycle after the grant. Expect no rd_valid for that read; after release, first round-robin grant goes to requester 0; rom_addr=0 during reset.
- Pixel-path priority: blank=1, req=4'b1111 for 10 cycles. Expect gnt=4'b0001 every cycle, last_gnt unchanged, rd_valid[0] each cycle one ROM_LAT later.
- Round-robin: blank=0, req=4'b1111 held. Expect gnt sequence 0001, 0010, 0100, 1000, 0001; each rd_data matches a ROM model at the granted address.
- Sparse wrap: blank=0, last_gnt=3, req=4'b0100. Expect gnt=0100. Then req=4'b0101: expect gnt=0001, then 0100.
- Mode switch with reads in flight: blank 0->1 while requester 3 is granted. Expect requester 3's rd_valid still arrives at t+ROM_LAT and requester 0 wins the next cycle.
- Idle/return: req=0 for 5 cycles. Expect gnt=0, rom_addr holds its last value, no rd_valid beyond outstanding reads.
